// File: rtl/caxi4interconnect_request_qual_arb.sv
// Request qualifier and round-robin arbiter for one crossbar master port.
// Ports: SLAVE_VALID/SLAVE_ID/READ_CONNECTIVITY in, registered grant and open-count status out.
module caxi4interconnect_request_qual_arb #(
  parameter int NUM_SLAVES        = 8,
  parameter int NUM_SLAVES_WIDTH  = 3,
  parameter int NUM_MASTERS_WIDTH = 1,
  parameter int ID_WIDTH          = 1,
  parameter int CROSSBAR_MODE     = 1,
  parameter int OPEN_TRANS_MAX    = 4,
  parameter int OPEN_TRANS_WIDTH  = 3
) (
  input  logic                          sysClk,
  input  logic                          sysReset,
  input  logic [NUM_SLAVES-1:0]         SLAVE_VALID,
  input  logic [3:0]                    MASTER_NUM,
  input  logic [NUM_SLAVES*(NUM_MASTERS_WIDTH+ID_WIDTH)-1:0] SLAVE_ID,
  input  logic [NUM_SLAVES-1:0]         READ_CONNECTIVITY,
  input  logic                          MASTER_READY,
  input  logic [NUM_SLAVES-1:0]         TRANS_DONE,
  output logic [NUM_SLAVES-1:0]         slaveValidQual,
  output logic                          grantValid,
  output logic [NUM_SLAVES-1:0]         grantOneHot,
  output logic [NUM_SLAVES_WIDTH-1:0]   grantEnc,
  output logic [NUM_SLAVES-1:0]         portBlocked,
  output logic                          countErr
);

  localparam int NS  = NUM_SLAVES;
  localparam int NSW = NUM_SLAVES_WIDTH;
  localparam int NMW = NUM_MASTERS_WIDTH;
  localparam int IDW = NUM_MASTERS_WIDTH + ID_WIDTH;
  localparam int OTW = OPEN_TRANS_WIDTH;
  localparam logic [OTW-1:0] MAX_C = OTW'(OPEN_TRANS_MAX);
  localparam logic [NS-1:0]  ONE_C = NS'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic                   gv_q, gv_d;
  logic [NS-1:0]          oh_q, oh_d;
  logic [NSW-1:0]         enc_q, enc_d;
  logic [NSW-1:0]         rr_q, rr_d;
  logic [NS-1:0][OTW-1:0] cnt_q, cnt_d;
  logic [NS-1:0]          blk_q, blk_d;
  logic                   err_q, err_d;
  logic [NS-1:0]          qual;
  logic                   pick_vld;
  logic [NSW-1:0]         pick_idx;
  logic                   hs;

  // Only the low NMW bits of MASTER_NUM and the target field of each ID matter.
  logic unused_ok;
  assign unused_ok = ^{MASTER_NUM, SLAVE_ID};

  always_comb begin
    logic [NMW-1:0] tgt;
    logic           hit;
    tgt  = '0;
    hit  = 1'b0;
    qual = '0;
    for (int i = 0; i < NS; i++) begin
      tgt = SLAVE_ID[i*IDW+ID_WIDTH +: NMW];
      hit = (CROSSBAR_MODE != 0) ?
            (tgt == MASTER_NUM[NMW-1:0]) : 1'b1;
      qual[i] = READ_CONNECTIVITY[i] & SLAVE_VALID[i]
              & hit & (cnt_q[i] < MAX_C);
    end
  end

  // First qualified index at or after rr_q, wrapping on NS.
  always_comb begin
    int             s;
    logic [NSW-1:0] j;
    s        = 0;
    j        = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NS; k++) begin
      s = int'(rr_q) + k;
      if (s >= NS) s = s - NS;
      j = NSW'(s);
      if (!pick_vld && qual[j]) begin
        pick_vld = 1'b1;
        pick_idx = j;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gv_d    = gv_q;
    oh_d    = oh_q;
    enc_d   = enc_q;
    rr_d    = rr_q;
    hs      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gv_d    = 1'b1;
          oh_d    = ONE_C << pick_idx;
          enc_d   = pick_idx;
        end
      end
      GRANT: begin
        if (MASTER_READY) begin
          hs      = 1'b1;
          rr_d    = (enc_q == NSW'(NS-1)) ?
                    '0 : enc_q + 1'b1;
          state_d = IDLE;
          gv_d    = 1'b0;
          oh_d    = '0;
          enc_d   = '0;
        end else if (!SLAVE_VALID[enc_q] ||
                     !READ_CONNECTIVITY[enc_q]) begin
          state_d = IDLE;
          gv_d    = 1'b0;
          oh_d    = '0;
          enc_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic inc;
    logic dec;
    inc   = 1'b0;
    dec   = 1'b0;
    cnt_d = cnt_q;
    err_d = err_q;
    blk_d = '0;
    for (int i = 0; i < NS; i++) begin
      inc = hs && (enc_q == NSW'(i));
      dec = TRANS_DONE[i];
      if (inc && !dec) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!inc && dec) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else cnt_d[i] = cnt_q[i] - 1'b1;
      end
      blk_d[i] = (cnt_d[i] == MAX_C);
    end
  end

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      state_q <= IDLE;
      gv_q    <= 1'b0;
      oh_q    <= '0;
      enc_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gv_q    <= gv_d;
      oh_q    <= oh_d;
      enc_q   <= enc_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
    end
  end

  assign slaveValidQual = qual;
  assign grantValid     = gv_q;
  assign grantOneHot    = oh_q;
  assign grantEnc       = enc_q;
  assign portBlocked    = blk_q;
  assign countErr       = err_q;

endmodule

// File: tb/tb_caxi4interconnect_request_qual_arb.sv
// Bench for caxi4interconnect_request_qual_arb: directed table on an 8-port
// crossbar instance, random traffic on both it and a 5-port shared-path instance.
module tb_caxi4interconnect_request_qual_arb;

  logic clk;
  logic rst_n;
  logic [3:0] mn;

  logic [15:0] iv  [2];
  logic [15:0] ic  [2];
  logic [15:0] idn [2];
  logic [31:0] iid [2];
  logic        ir  [2];

  logic [15:0] o_qual [2];
  logic        o_gv   [2];
  logic [15:0] o_oh   [2];
  logic [2:0]  o_enc  [2];
  logic [15:0] o_blk  [2];
  logic        o_err  [2];

  logic [7:0] a_qual, a_oh, a_blk;
  logic       a_gv, a_err;
  logic [2:0] a_enc;
  logic [4:0] b_qual, b_oh, b_blk;
  logic       b_gv, b_err;
  logic [2:0] b_enc;

  int nchk;
  int nerr;

  caxi4interconnect_request_qual_arb u_a (
    .sysClk            (clk),
    .sysReset          (rst_n),
    .SLAVE_VALID       (iv[0][7:0]),
    .MASTER_NUM        (mn),
    .SLAVE_ID          (iid[0][15:0]),
    .READ_CONNECTIVITY (ic[0][7:0]),
    .MASTER_READY      (ir[0]),
    .TRANS_DONE        (idn[0][7:0]),
    .slaveValidQual    (a_qual),
    .grantValid        (a_gv),
    .grantOneHot       (a_oh),
    .grantEnc          (a_enc),
    .portBlocked       (a_blk),
    .countErr          (a_err)
  );

  caxi4interconnect_request_qual_arb #(
    .NUM_SLAVES        (5),
    .NUM_SLAVES_WIDTH  (3),
    .NUM_MASTERS_WIDTH (1),
    .ID_WIDTH          (1),
    .CROSSBAR_MODE     (0),
    .OPEN_TRANS_MAX    (3),
    .OPEN_TRANS_WIDTH  (2)
  ) u_b (
    .sysClk            (clk),
    .sysReset          (rst_n),
    .SLAVE_VALID       (iv[1][4:0]),
    .MASTER_NUM        (mn),
    .SLAVE_ID          (iid[1][9:0]),
    .READ_CONNECTIVITY (ic[1][4:0]),
    .MASTER_READY      (ir[1]),
    .TRANS_DONE        (idn[1][4:0]),
    .slaveValidQual    (b_qual),
    .grantValid        (b_gv),
    .grantOneHot       (b_oh),
    .grantEnc          (b_enc),
    .portBlocked       (b_blk),
    .countErr          (b_err)
  );

  assign o_qual[0] = {8'h0, a_qual};
  assign o_gv[0]   = a_gv;
  assign o_oh[0]   = {8'h0, a_oh};
  assign o_enc[0]  = a_enc;
  assign o_blk[0]  = {8'h0, a_blk};
  assign o_err[0]  = a_err;
  assign o_qual[1] = {11'h0, b_qual};
  assign o_gv[1]   = b_gv;
  assign o_oh[1]   = {11'h0, b_oh};
  assign o_enc[1]  = b_enc;
  assign o_blk[1]  = {11'h0, b_blk};
  assign o_err[1]  = b_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-instance transaction counts, pointer and grant.
  int cfg_n   [2] = '{8, 5};
  int cfg_x   [2] = '{1, 0};
  int cfg_max [2] = '{4, 3};
  int m_cnt [2][16];
  int m_rr  [2];
  int m_g   [2];
  bit m_gv  [2];
  bit m_err [2];

  task automatic mreset(int k);
    for (int i = 0; i < 16; i++) m_cnt[k][i] = 0;
    m_rr[k]  = 0;
    m_g[k]   = 0;
    m_gv[k]  = 0;
    m_err[k] = 0;
  endtask

  function automatic logic [15:0] mqual(int k);
    logic [15:0] q;
    bit hit;
    q = '0;
    for (int i = 0; i < cfg_n[k]; i++) begin
      hit  = (cfg_x[k] == 0) || (iid[k][2*i+1] == mn[0]);
      q[i] = iv[k][i] && ic[k][i] && hit
             && (m_cnt[k][i] < cfg_max[k]);
    end
    return q;
  endfunction

  task automatic mstep(int k);
    logic [15:0] q;
    int inc;
    bit found;
    int j;
    q = mqual(k);
    inc = -1;
    found = 0;
    if (m_gv[k]) begin
      if (ir[k]) begin
        inc = m_g[k];
        m_rr[k] = (m_g[k] + 1) % cfg_n[k];
        m_gv[k] = 0;
      end else if (!iv[k][m_g[k]] || !ic[k][m_g[k]]) begin
        m_gv[k] = 0;
      end
    end else begin
      for (int s = 0; s < cfg_n[k]; s++) begin
        j = (m_rr[k] + s) % cfg_n[k];
        if (!found && q[j]) begin
          found = 1;
          m_gv[k] = 1;
          m_g[k] = j;
        end
      end
    end
    for (int i = 0; i < cfg_n[k]; i++) begin
      if (inc == i && idn[k][i]) begin
      end else if (inc == i) begin
        m_cnt[k][i]++;
      end else if (idn[k][i]) begin
        if (m_cnt[k][i] == 0) m_err[k] = 1;
        else m_cnt[k][i]--;
      end
    end
  endtask

  task automatic mcheck(int k);
    logic [15:0] eoh, eblk;
    eoh  = m_gv[k] ? (16'h1 << m_g[k]) : 16'h0;
    eblk = '0;
    for (int i = 0; i < cfg_n[k]; i++)
      eblk[i] = (m_cnt[k][i] == cfg_max[k]);
    chk($sformatf("rnd%0d qual", k), 32'(o_qual[k]), 32'(mqual(k)));
    chk($sformatf("rnd%0d gv", k), 32'(o_gv[k]), 32'(m_gv[k]));
    chk($sformatf("rnd%0d oh", k), 32'(o_oh[k]), 32'(eoh));
    chk($sformatf("rnd%0d enc", k), 32'(o_enc[k]),
        m_gv[k] ? 32'(m_g[k]) : 32'h0);
    chk($sformatf("rnd%0d blk", k), 32'(o_blk[k]), 32'(eblk));
    chk($sformatf("rnd%0d err", k), 32'(o_err[k]), 32'(m_err[k]));
  endtask

  typedef struct {
    logic [7:0] v;
    logic       r;
    logic [7:0] d;
    logic [7:0] q;
    logic       gv;
    logic [2:0] enc;
    logic [7:0] blk;
    logic       err;
  } vec_t;

  vec_t tbl [29];

  function automatic vec_t mk(logic [7:0] v, logic r, logic [7:0] d,
                              logic [7:0] q, logic gv, logic [2:0] enc,
                              logic [7:0] blk, logic err);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.q = q;
    t.gv = gv; t.enc = enc; t.blk = blk; t.err = err;
    return t;
  endfunction

  initial begin
    nchk = 0;
    nerr = 0;
    tbl[0]  = mk(8'h04, 0, 8'h00, 8'h04, 0, 0, 8'h00, 0);
    tbl[1]  = mk(8'h04, 1, 8'h00, 8'h04, 1, 2, 8'h00, 0);
    tbl[2]  = mk(8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0);
    tbl[3]  = mk(8'h29, 1, 8'h00, 8'h29, 0, 0, 8'h00, 0);
    tbl[4]  = mk(8'h29, 1, 8'h00, 8'h29, 1, 3, 8'h00, 0);
    tbl[5]  = mk(8'h29, 1, 8'h00, 8'h29, 0, 0, 8'h00, 0);
    tbl[6]  = mk(8'h29, 1, 8'h00, 8'h29, 1, 5, 8'h00, 0);
    tbl[7]  = mk(8'h29, 1, 8'h00, 8'h29, 0, 0, 8'h00, 0);
    tbl[8]  = mk(8'h29, 1, 8'h00, 8'h29, 1, 0, 8'h00, 0);
    tbl[9]  = mk(8'h29, 1, 8'h00, 8'h29, 0, 0, 8'h00, 0);
    tbl[10] = mk(8'h29, 1, 8'h00, 8'h29, 1, 3, 8'h00, 0);
    tbl[11] = mk(8'h29, 0, 8'h00, 8'h29, 0, 0, 8'h00, 0);
    tbl[12] = mk(8'h09, 0, 8'h00, 8'h09, 1, 5, 8'h00, 0);
    tbl[13] = mk(8'h09, 0, 8'h00, 8'h09, 0, 0, 8'h00, 0);
    tbl[14] = mk(8'h09, 1, 8'h08, 8'h09, 1, 0, 8'h00, 0);
    tbl[15] = mk(8'h00, 0, 8'h40, 8'h00, 0, 0, 8'h00, 0);
    tbl[16] = mk(8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 1);
    tbl[17] = mk(8'h02, 1, 8'h00, 8'h02, 0, 0, 8'h00, 1);
    tbl[18] = mk(8'h02, 1, 8'h00, 8'h02, 1, 1, 8'h00, 1);
    tbl[19] = mk(8'h02, 1, 8'h00, 8'h02, 0, 0, 8'h00, 1);
    tbl[20] = mk(8'h02, 1, 8'h00, 8'h02, 1, 1, 8'h00, 1);
    tbl[21] = mk(8'h02, 1, 8'h00, 8'h02, 0, 0, 8'h00, 1);
    tbl[22] = mk(8'h02, 1, 8'h00, 8'h02, 1, 1, 8'h00, 1);
    tbl[23] = mk(8'h02, 1, 8'h00, 8'h02, 0, 0, 8'h00, 1);
    tbl[24] = mk(8'h02, 1, 8'h00, 8'h02, 1, 1, 8'h00, 1);
    tbl[25] = mk(8'h02, 1, 8'h00, 8'h00, 0, 0, 8'h02, 1);
    tbl[26] = mk(8'h02, 1, 8'h02, 8'h00, 0, 0, 8'h02, 1);
    tbl[27] = mk(8'h02, 0, 8'h00, 8'h02, 0, 0, 8'h00, 1);
    tbl[28] = mk(8'h02, 0, 8'h00, 8'h02, 1, 1, 8'h00, 1);

    rst_n = 1'b0;
    mn = 4'd1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = '0; ic[k] = '0; idn[k] = '0; iid[k] = '0; ir[k] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst gv", 32'(a_gv), 0);
    chk("rst oh", 32'(a_oh), 0);
    chk("rst enc", 32'(a_enc), 0);
    chk("rst blk", 32'(a_blk), 0);
    chk("rst err", 32'(a_err), 0);
    rst_n = 1'b1;

    ic[0]  = 16'h00FF;
    iid[0] = 32'h0000AAAA;
    for (int r = 0; r < 29; r++) begin
      iv[0]  = {8'h0, tbl[r].v};
      ir[0]  = tbl[r].r;
      idn[0] = {8'h0, tbl[r].d};
      #1;
      chk($sformatf("tbl%0d qual", r), 32'(a_qual), 32'(tbl[r].q));
      chk($sformatf("tbl%0d gv", r), 32'(a_gv), 32'(tbl[r].gv));
      chk($sformatf("tbl%0d enc", r), 32'(a_enc), 32'(tbl[r].enc));
      chk($sformatf("tbl%0d oh", r), 32'(a_oh),
          tbl[r].gv ? (32'h1 << tbl[r].enc) : 32'h0);
      chk($sformatf("tbl%0d blk", r), 32'(a_blk), 32'(tbl[r].blk));
      chk($sformatf("tbl%0d err", r), 32'(a_err), 32'(tbl[r].err));
      @(posedge clk);
      @(negedge clk);
    end

    // Asynchronous reset while a grant is held.
    idn[0] = '0;
    ir[0]  = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst gv", 32'(a_gv), 0);
    chk("arst oh", 32'(a_oh), 0);
    chk("arst enc", 32'(a_enc), 0);
    chk("arst err", 32'(a_err), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    iv[0]  = 16'h00FF;
    #1;
    chk("arst qual", 32'(a_qual), 32'hFF);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("arst first gv", 32'(a_gv), 1);
    chk("arst first enc", 32'(a_enc), 0);

    // Random traffic on both instances against the model.
    @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = '0; ic[k] = '0; idn[k] = '0; ir[k] = 1'b0;
      mreset(k);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) mn = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        iv[k]  = 16'($urandom) | 16'($urandom);
        ic[k]  = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
        iid[k] = $urandom;
        ir[k]  = ($urandom_range(0, 2) != 0);
        idn[k] = '0;
        for (int i = 0; i < cfg_n[k]; i++) begin
          if (m_cnt[k][i] > 0 && $urandom_range(0, 4) == 0)
            idn[k][i] = 1'b1;
          else if ($urandom_range(0, 499) == 0)
            idn[k][i] = 1'b1;
        end
      end
      #1;
      mcheck(0);
      mcheck(1);
      @(posedge clk);
      mstep(0);
      mstep(1);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/caxi4interconnect_request_qual_arb.md
Name: caxi4interconnect_request_qual_arb

Overview:
Registered request qualifier and round-robin arbiter for one target master port of the crossbar. It qualifies each slave-port request by connectivity, target decode and per-port outstanding-transaction limit. It then grants one request and holds the grant until the master accepts it. It tracks open transactions per slave port so that no port exceeds OPEN_TRANS_MAX outstanding transactions to this master.

Parameters:
NUM_SLAVES, 8, number of slave-port requestors (2..16)
NUM_SLAVES_WIDTH, 3, encoded grant width, ceil(log2(NUM_SLAVES))
NUM_MASTERS_WIDTH, 1, bits encoding target master number (1..4)
ID_WIDTH, 1, transaction ID width below the infrastructure field
CROSSBAR_MODE, 1, 1 = match target master; 0 = shared path, all connected requestors compete
OPEN_TRANS_MAX, 4, max outstanding transactions per slave port to this master (1..2^OPEN_TRANS_WIDTH-1)
OPEN_TRANS_WIDTH, 3, width of each open-transaction counter

Ports:
sysClk  in  1  clock, all state rising-edge
sysReset  in  1  asynchronous active-low reset
SLAVE_VALID  in  NUM_SLAVES  per-port address valid
MASTER_NUM  in  4  this master's number; low NUM_MASTERS_WIDTH bits used
SLAVE_ID  in  NUM_SLAVES*(NUM_MASTERS_WIDTH+ID_WIDTH)  per-port ID; target field = upper NUM_MASTERS_WIDTH bits of each slice
READ_CONNECTIVITY  in  NUM_SLAVES  per-port connectivity enable
MASTER_READY  in  1  master accepts granted address this cycle
TRANS_DONE  in  NUM_SLAVES  one-cycle pulse: final response for one transaction of that port completed
slaveValidQual  out  NUM_SLAVES  combinational qualified requests
grantValid  out  1  registered grant valid
grantOneHot  out  NUM_SLAVES  registered one-hot grant
grantEnc  out  NUM_SLAVES_WIDTH  registered encoded grant
portBlocked  out  NUM_SLAVES  registered: counter[i] == OPEN_TRANS_MAX
countErr  out  1  sticky: TRANS_DONE received with counter 0

Behaviour:
- Qualification (combinational): slaveValidQual[i] = READ_CONNECTIVITY[i] & SLAVE_VALID[i] & (CROSSBAR_MODE ? target[i]==MASTER_NUM[NUM_MASTERS_WIDTH-1:0] : 1) & (openCnt[i] < OPEN_TRANS_MAX).
- Reset (sysReset low, asynchronous): grantValid=0, grantOneHot=0, grantEnc=0, portBlocked=0, countErr=0, all openCnt=0, rrPtr=0, state=IDLE. Release is synchronous to sysClk.
- FSM IDLE:
  - If any slaveValidQual bit is set, select the first set index scanning upward from rrPtr with wrap at NUM_SLAVES-1 -> 0.
  - Register the grant (grantValid=1, one-hot and encoded) and go to GRANT.
  - Latency: request qualified in cycle N -> grantValid high in cycle N+1.
- FSM GRANT:
  - Grant outputs are held stable.
  - Handshake = grantValid & MASTER_READY. On handshake: openCnt[g]++, rrPtr = (g+1) mod NUM_SLAVES, clear grant, go IDLE. This inserts one bubble cycle, so the maximum is one grant per 2 cycles.
  - If SLAVE_VALID[g] or READ_CONNECTIVITY[g] drops without a handshake: withdraw the grant, go IDLE. No count change, rrPtr unchanged.
  - Qualification changes on other ports do not preempt the grant.
  - The open-limit term is not re-evaluated for g while in GRANT.
- Counters:
  - TRANS_DONE[i] decrements openCnt[i].
  - Handshake on port i and TRANS_DONE[i] in the same cycle: net unchanged.
  - TRANS_DONE[i] with openCnt[i]==0 and no simultaneous increment: counter stays 0, countErr set (cleared only by reset).
  - Counters never exceed OPEN_TRANS_MAX, because qualification blocks requests at the limit.
  - TRANS_DONE on several ports in one cycle is handled independently per port.
- portBlocked[i] is registered from the next-state counter value, so it is valid the same cycle the counter updates.
- No qualified requests: stay in IDLE, outputs 0.
- NUM_SLAVES not a power of 2: rrPtr wrap uses a NUM_SLAVES modulus, not the bit width.

Test Plan:
- CROSSBAR_MODE=1, MASTER_NUM=1, port 2 valid with target=1 and connected -> slaveValidQual=0x04, grantValid in the next cycle, grantEnc=2. MASTER_READY=1 -> openCnt[2]=1, back to IDLE.
- Ports 0, 3, 5 requesting continuously, MASTER_READY always 1 -> grant order 0, 3, 5, 0, 3, 5, with one grant every 2 cycles.
- OPEN_TRANS_MAX=4, port 1 gets 4 handshakes and no TRANS_DONE -> portBlocked[1]=1 and slaveValidQual[1]=0. One TRANS_DONE[1] -> requalified and granted again.
- Handshake on port 4 in the same cycle as TRANS_DONE[4] with openCnt=2 -> openCnt stays 2. TRANS_DONE[6] with openCnt[6]=0 -> countErr=1 and stays set.
- CROSSBAR_MODE=0, ports 1 and 7 targeting different masters -> both qualify and are arbitrated round-robin. With READ_CONNECTIVITY[7]=0, port 7 is never granted.
- sysReset asserted while in GRANT with openCnt values nonzero -> all outputs 0 immediately, without waiting for a clock edge. After release, the first grant starts from index 0.
